// File: rtl/mips_data_memory.sv
// Word-addressed data memory for the MIPS load/store port, answering each request after LATENCY edges.
// One request in flight at a time; requests are only sampled while idle.
module mips_data_memory #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        busy,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state;
  logic [4:0]            cnt;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  rd_q;
  logic                  wr_q;
  logic                  err_q;
  logic [31:0]           mem [2**ADDR_WIDTH];

  logic                  acc_en;
  logic                  acc_rd;
  logic                  acc_wr;
  logic                  acc_bad;
  logic [ADDR_WIDTH+1:0] acc_addr;
  logic [31:0]           acc_wdata;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic                  unused_addr;

  assign unused_addr = ^address[31:ADDR_WIDTH+2];

  // With LATENCY==1 the access happens on the accepting edge, so it uses the live inputs.
  always_comb begin
    acc_rd    = rd_q;
    acc_wr    = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_en    = 1'b0;
    if (state == IDLE) begin
      acc_rd    = memRead;
      acc_wr    = memWrite;
      acc_addr  = address[ADDR_WIDTH+1:0];
      acc_wdata = writeData;
      acc_en    = !rst && (memRead || memWrite) && (LATENCY == 1);
    end else if (state == WAIT) begin
      acc_en = !rst && (cnt == 5'd1);
    end
    acc_bad = (acc_addr[1:0] != 2'b00) || (acc_rd && acc_wr);
    acc_idx = acc_addr[ADDR_WIDTH+1:2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      readData <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (memRead || memWrite) begin
            addr_q  <= address[ADDR_WIDTH+1:0];
            wdata_q <= writeData;
            rd_q    <= memRead;
            wr_q    <= memWrite;
            cnt     <= 5'(LATENCY - 1);
            state   <= (LATENCY == 1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 5'd1) state <= DONE;
          else             cnt   <= cnt - 5'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (acc_en) begin
        err_q <= acc_bad;
        if (acc_bad)     readData <= 32'd0;
        else if (acc_rd) readData <= mem[acc_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc_en && acc_wr && !acc_bad) mem[acc_idx] <= acc_wdata;
  end

  assign ready = (state == DONE);
  assign busy  = (state != IDLE);
  assign error = (state == DONE) && err_q;

endmodule

// File: tb/tb_mips_data_memory.sv
// Directed bench: three memory instances at LATENCY 2, 4 and 1 with hand-computed expectations.
module tb_mips_data_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst = 1'b1, a_rd = 1'b1, a_wr = 1'b0;
  logic [31:0] a_addr = 32'd0, a_wdata = 32'd0, a_rdata;
  logic        a_ready, a_busy, a_error;

  logic        b_rst = 1'b1, b_rd = 1'b0, b_wr = 1'b0;
  logic [31:0] b_addr = 32'd0, b_wdata = 32'd0, b_rdata;
  logic        b_ready, b_busy, b_error;

  logic        c_rst = 1'b1, c_rd = 1'b0, c_wr = 1'b0;
  logic [31:0] c_addr = 32'd0, c_wdata = 32'd0, c_rdata;
  logic        c_ready, c_busy, c_error;

  mips_data_memory #(.ADDR_WIDTH(10), .LATENCY(2)) dut_a (
    .clk(clk), .rst(a_rst), .memRead(a_rd), .memWrite(a_wr), .address(a_addr),
    .writeData(a_wdata), .readData(a_rdata), .ready(a_ready), .busy(a_busy), .error(a_error));

  mips_data_memory #(.ADDR_WIDTH(10), .LATENCY(4)) dut_b (
    .clk(clk), .rst(b_rst), .memRead(b_rd), .memWrite(b_wr), .address(b_addr),
    .writeData(b_wdata), .readData(b_rdata), .ready(b_ready), .busy(b_busy), .error(b_error));

  mips_data_memory #(.ADDR_WIDTH(10), .LATENCY(1)) dut_c (
    .clk(clk), .rst(c_rst), .memRead(c_rd), .memWrite(c_wr), .address(c_addr),
    .writeData(c_wdata), .readData(c_rdata), .ready(c_ready), .busy(c_busy), .error(c_error));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vt[9];

  // Precondition: dut_a idle, called 1 time unit after a rising edge.
  task automatic a_req(input logic rd, input logic wr, input logic [31:0] ad, input logic [31:0] wd,
                       output logic [31:0] data, output logic err, output logic rdy, output int edges);
    a_rd = rd; a_wr = wr; a_addr = ad; a_wdata = wd;
    @(posedge clk); #1;
    a_rd = 1'b0; a_wr = 1'b0;
    chk("a_busy_after_accept", {31'd0, a_busy}, 32'd1);
    edges = 0;
    while (!a_ready && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    data = a_rdata; err = a_error; rdy = a_ready;
    @(posedge clk); #1;
    chk("a_idle_after_done", {30'd0, a_busy, a_ready}, 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic        e, r;
    int          n, pulses;

    vt[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vt[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vt[2] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0};
    vt[3] = '{1'b1, 1'b0, 32'h0000_1FFC, 32'h0000_0000, 32'h1234_5678, 1'b0};
    vt[4] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[5] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vt[6] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vt[7] = '{1'b0, 1'b1, 32'h0000_0012, 32'h0000_00FF, 32'h0000_0000, 1'b1};
    vt[8] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};

    // Reset held two cycles with a read request pending.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_ready", {31'd0, a_ready}, 32'd0);
      chk("rst_busy",  {31'd0, a_busy},  32'd0);
      chk("rst_error", {31'd0, a_error}, 32'd0);
      chk("rst_rdata", a_rdata, 32'd0);
    end
    a_rst = 1'b0; a_rd = 1'b0;
    b_rst = 1'b0; c_rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", {31'd0, a_busy}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      a_req(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, d, e, r, n);
      chk($sformatf("v%0d_ready", i), {31'd0, r}, 32'd1);
      chk($sformatf("v%0d_latency", i), n, 32'd1);
      chk($sformatf("v%0d_rdata", i), d, vt[i].exp_data);
      chk($sformatf("v%0d_error", i), {31'd0, e}, {31'd0, vt[i].exp_err});
    end

    // LATENCY=4: establish prior contents, then abort a store by reset during WAIT.
    b_wr = 1'b1; b_addr = 32'h20; b_wdata = 32'h1111_2222;
    @(posedge clk); #1;
    b_wr = 1'b0;
    n = 0;
    while (!b_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("b_store_latency", n, 32'd3);
    @(posedge clk); #1;
    b_wr = 1'b1; b_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    b_wr = 1'b0;
    chk("b_wait_busy", {31'd0, b_busy}, 32'd1);
    chk("b_wait_ready0", {31'd0, b_ready}, 32'd0);
    @(posedge clk); #1;
    chk("b_wait_ready1", {31'd0, b_ready}, 32'd0);
    b_rst = 1'b1;
    @(posedge clk); #1;
    b_rst = 1'b0;
    chk("b_abort_busy",  {31'd0, b_busy},  32'd0);
    chk("b_abort_ready", {31'd0, b_ready}, 32'd0);
    chk("b_abort_rdata", b_rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("b_no_late_ready", {31'd0, b_ready}, 32'd0);
    end
    b_rd = 1'b1;
    @(posedge clk); #1;
    b_rd = 1'b0;
    n = 0;
    while (!b_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("b_load_latency", n, 32'd3);
    chk("b_load_rdata", b_rdata, 32'h1111_2222);
    chk("b_load_error", {31'd0, b_error}, 32'd0);
    @(posedge clk); #1;

    // LATENCY=1: store completes in the cycle after the accepting edge.
    c_wr = 1'b1; c_addr = 32'h8; c_wdata = 32'h0000_0077;
    @(posedge clk); #1;
    c_wr = 1'b0;
    chk("c_store_ready", {31'd0, c_ready}, 32'd1);
    @(posedge clk); #1;
    chk("c_store_idle", {31'd0, c_busy}, 32'd0);

    // Held read: accepted only from IDLE, so ready alternates every cycle.
    c_rd = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("c_held_ready%0d", i), {31'd0, c_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("c_held_busy%0d", i),  {31'd0, c_busy},  (i % 2 == 0) ? 32'd1 : 32'd0);
      if (c_ready) begin
        pulses++;
        chk($sformatf("c_held_rdata%0d", i), c_rdata, 32'h0000_0077);
      end
    end
    c_rd = 1'b0;
    chk("c_held_pulses", pulses, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
